// File: rtl/morph_pkg.sv
// Shared types and default geometry for the
// eye-tracking mask stages.
package morph_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    REPORT
  } state_t;

  localparam int IMG_W_D   = 640;
  localparam int IMG_H_D   = 480;
  localparam int COORD_W_D = 12;
  localparam int CNT_W_D   = 20;
  localparam int MIN_RUN_D = 3;
  localparam int MIN_PIX_D = 64;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a single
// rise- or fall-edge pulse output.
module sync_edge_det #(
  parameter bit RISE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic r0;
  logic r1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0 <= 1'b0;
      r1 <= 1'b0;
    end else begin
      r0 <= sig;
      r1 <= r0;
    end
  end

  assign pulse = RISE ? (r0 & ~r1)
                      : (~r0 & r1);

endmodule

// File: rtl/eye_bbox_track.sv
// Per-frame bounding box and pixel count of
// run-filtered foreground in a binary mask.
module eye_bbox_track
  import morph_pkg::*;
#(
  parameter int IMG_W   = IMG_W_D,
  parameter int IMG_H   = IMG_H_D,
  parameter int COORD_W = COORD_W_D,
  parameter int CNT_W   = CNT_W_D,
  parameter int MIN_RUN = MIN_RUN_D,
  parameter int MIN_PIX = MIN_PIX_D
) (
  input  logic               module_clk,
  input  logic               module_rst_n,
  input  logic               cam_href,
  input  logic               cam_vsync,
  input  logic               din_val,
  input  logic               din,
  output logic               bbox_valid,
  output logic               bbox_found,
  output logic [COORD_W-1:0] bbox_x_min,
  output logic [COORD_W-1:0] bbox_x_max,
  output logic [COORD_W-1:0] bbox_y_min,
  output logic [COORD_W-1:0] bbox_y_max,
  output logic [CNT_W-1:0]   pix_count
);

  localparam logic [COORD_W-1:0] W_C =
    COORD_W'(IMG_W);
  localparam logic [COORD_W-1:0] H_C =
    COORD_W'(IMG_H);
  localparam logic [COORD_W-1:0] BACK =
    COORD_W'(MIN_RUN - 1);
  localparam logic [4:0] MR5 = 5'(MIN_RUN);
  localparam logic [3:0] MR4 = 4'(MIN_RUN);
  localparam logic [CNT_W:0] ADD_RUN =
    (CNT_W+1)'(MIN_RUN);
  localparam logic [CNT_W:0] ADD_ONE =
    (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] PIX_C =
    CNT_W'(MIN_PIX);

  logic vs_rise;
  logic hs_fall;

  sync_edge_det #(.RISE(1'b1)) u_vs (
    .clk   (module_clk),
    .rst_n (module_rst_n),
    .sig   (cam_vsync),
    .pulse (vs_rise)
  );

  sync_edge_det #(.RISE(1'b0)) u_hs (
    .clk   (module_clk),
    .rst_n (module_rst_n),
    .sig   (cam_href),
    .pulse (hs_fall)
  );

  state_t state;
  state_t state_nx;
  logic   active;
  logic   report;

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) state <= IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    active   = 1'b0;
    report   = 1'b0;
    unique case (state)
      IDLE: begin
        if (vs_rise) state_nx = ACTIVE;
      end
      ACTIVE: begin
        active = 1'b1;
        if (vs_rise) state_nx = REPORT;
      end
      REPORT: begin
        report   = 1'b1;
        state_nx = ACTIVE;
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;
  logic [3:0]         run;
  logic [4:0]         run1;
  logic               pix_v;
  logic               qual;
  logic               first;
  logic [COORD_W-1:0] x_lo;

  assign run1  = {1'b0, run} + 5'd1;
  assign pix_v = active & din_val
               & ~vs_rise & ~hs_fall;
  assign first = (run1 == MR5);
  assign qual  = pix_v & din
               & (run1 >= MR5)
               & (col < W_C)
               & (row < H_C);
  assign x_lo  = first ? (col - BACK) : col;

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      col <= '0;
      row <= '0;
      run <= '0;
    end else if (vs_rise) begin
      col <= '0;
      row <= '0;
      run <= '0;
    end else if (hs_fall) begin
      col <= '0;
      run <= '0;
      if (row != H_C) row <= row + 1'b1;
    end else if (pix_v) begin
      if (col != W_C) col <= col + 1'b1;
      if (!din)             run <= '0;
      else if (run1 >= MR5) run <= MR4;
      else                  run <= run1[3:0];
    end
  end

  logic [COORD_W-1:0] x_min;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] y_min;
  logic [COORD_W-1:0] y_max;
  logic [CNT_W-1:0]   cnt;
  logic               any;
  logic [CNT_W:0]     sum;

  assign sum = {1'b0, cnt}
             + (first ? ADD_RUN : ADD_ONE);

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n || report) begin
      x_min <= '1;
      x_max <= '0;
      y_min <= '1;
      y_max <= '0;
      cnt   <= '0;
      any   <= 1'b0;
    end else if (qual) begin
      any <= 1'b1;
      if (x_lo < x_min) x_min <= x_lo;
      if (col > x_max)  x_max <= col;
      if (row < y_min)  y_min <= row;
      if (row > y_max)  y_max <= row;
      // saturate rather than wrap on huge blobs
      cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      bbox_valid <= 1'b0;
      bbox_found <= 1'b0;
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
      pix_count  <= '0;
    end else begin
      bbox_valid <= report;
      if (report) begin
        bbox_found <= (cnt >= PIX_C);
        pix_count  <= cnt;
        bbox_x_min <= any ? x_min : '0;
        bbox_x_max <= any ? x_max : '0;
        bbox_y_min <= any ? y_min : '0;
        bbox_y_max <= any ? y_max : '0;
      end
    end
  end

endmodule

// File: tb/tb_eye_bbox_track.sv
// Bench for eye_bbox_track: directed and random
// frames against a run-list reference model.
module tb_eye_bbox_track;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int MR = 3;
  localparam int MP = 64;
  localparam int CMAX = 1048575;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        href = 1'b0;
  logic        vsync = 1'b0;
  logic        val = 1'b0;
  logic        din = 1'b0;
  logic        bbox_valid;
  logic        bbox_found;
  logic [11:0] bbox_x_min;
  logic [11:0] bbox_x_max;
  logic [11:0] bbox_y_min;
  logic [11:0] bbox_y_max;
  logic [19:0] pix_count;

  always #5 clk = ~clk;

  eye_bbox_track dut (
    .module_clk   (clk),
    .module_rst_n (rst_n),
    .cam_href     (href),
    .cam_vsync    (vsync),
    .din_val      (val),
    .din          (din),
    .bbox_valid   (bbox_valid),
    .bbox_found   (bbox_found),
    .bbox_x_min   (bbox_x_min),
    .bbox_x_max   (bbox_x_max),
    .bbox_y_min   (bbox_y_min),
    .bbox_y_max   (bbox_y_max),
    .pix_count    (pix_count)
  );

  typedef struct {
    int xmin;
    int xmax;
    int ymin;
    int ymax;
    int cnt;
    int found;
  } rep_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  rep_t held = '{default: 0};
  rep_t exp_q[$];
  int   due_q[$];

  int axmin, axmax, aymin, aymax, acnt;
  bit aany;
  int arow;
  bit armed = 1'b0;

  logic [1:0] lq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // one compare per cycle: pulse timing + held outputs
  always @(negedge clk) begin
    if (due_q.size() > 0 && cyc == due_q[0]) begin
      chk("valid_pulse", 32'(bbox_valid), 1);
      held = exp_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      chk("valid_idle", 32'(bbox_valid), 0);
    end
    chk("x_min", 32'(bbox_x_min), held.xmin);
    chk("x_max", 32'(bbox_x_max), held.xmax);
    chk("y_min", 32'(bbox_y_min), held.ymin);
    chk("y_max", 32'(bbox_y_max), held.ymax);
    chk("count", 32'(pix_count), held.cnt);
    chk("found", 32'(bbox_found), held.found);
  end

  task automatic lit(input string nm,
                     input int xmn, input int xmx,
                     input int ymn, input int ymx,
                     input int c, input int f);
    chk({nm, ".x_min"}, 32'(bbox_x_min), xmn);
    chk({nm, ".x_max"}, 32'(bbox_x_max), xmx);
    chk({nm, ".y_min"}, 32'(bbox_y_min), ymn);
    chk({nm, ".y_max"}, 32'(bbox_y_max), ymx);
    chk({nm, ".count"}, 32'(pix_count), c);
    chk({nm, ".found"}, 32'(bbox_found), f);
  endtask

  task automatic acc_clear();
    axmin = 0; axmax = 0; aymin = 0; aymax = 0;
    acnt = 0; aany = 1'b0; arow = 0;
  endtask

  function automatic rep_t mk_rep();
    rep_t r;
    r.cnt   = (acnt > CMAX) ? CMAX : acnt;
    r.found = (r.cnt >= MP) ? 1 : 0;
    r.xmin  = aany ? axmin : 0;
    r.xmax  = aany ? axmax : 0;
    r.ymin  = aany ? aymin : 0;
    r.ymax  = aany ? aymax : 0;
    return r;
  endfunction

  // a run of len pixels starting at column s
  task automatic close_run(input int s, input int len);
    int hi;
    if (len < MR || arow >= H || s + MR - 1 >= W)
      return;
    hi = s + len - 1;
    if (hi > W - 1) hi = W - 1;
    acnt += hi - s + 1;
    if (!aany || s < axmin)    axmin = s;
    if (!aany || hi > axmax)   axmax = hi;
    if (!aany || arow < aymin) aymin = arow;
    if (!aany || arow > aymax) aymax = arow;
    aany = 1'b1;
  endtask

  task automatic model_line();
    int c = 0;
    int s = 0;
    int len = 0;
    foreach (lq[i]) begin
      if (lq[i][1]) begin
        if (lq[i][0]) begin
          if (len == 0) s = c;
          len++;
        end else begin
          close_run(s, len);
          len = 0;
        end
        c++;
      end
    end
    close_run(s, len);
  endtask

  task automatic tick(input logic h, input logic v,
                      input logic pv, input logic pd);
    @(posedge clk);
    #1;
    href = h; vsync = v; val = pv; din = pd;
  endtask

  task automatic frame_start();
    tick(0, 1, 0, 0);
    if (armed) begin
      exp_q.push_back(mk_rep());
      due_q.push_back(cyc + 3);
    end
    armed = 1'b1;
    acc_clear();
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
  endtask

  task automatic send_line();
    model_line();
    if (lq.size() == 0) tick(1, 0, 0, 0);
    foreach (lq[i]) tick(1, 0, lq[i][1], lq[i][0]);
    repeat (4) tick(0, 0, 0, 0);
    arow++;
  endtask

  task automatic empty_lines(input int n);
    lq.delete();
    repeat (n) send_line();
  endtask

  task automatic mk_line(input int n, input int lo,
                         input int hi);
    lq.delete();
    for (int i = 0; i < n; i++)
      lq.push_back({1'b1, (i >= lo && i <= hi)});
  endtask

  task automatic mk_pat(input int n,
                        input logic [63:0] pat);
    lq.delete();
    for (int i = 0; i < n; i++)
      lq.push_back({1'b1, pat[i]});
  endtask

  task automatic mk_rand();
    int n;
    lq.delete();
    if ($urandom_range(0, 7) == 0)
      n = $urandom_range(630, 660);
    else
      n = $urandom_range(0, 40);
    for (int i = 0; i < n; i++)
      lq.push_back({($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 2) != 0)});
  endtask

  initial begin
    acc_clear();
    repeat (3) tick(0, 0, 0, 0);
    lit("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) tick(0, 0, 0, 0);

    // foreground before the first vsync is discarded
    mk_line(10, 2, 8);
    send_line();
    frame_start();
    empty_lines(2);
    frame_start();
    lit("zero_frame", 0, 0, 0, 0, 0, 0);

    empty_lines(10);
    mk_line(110, 100, 104);
    send_line();
    frame_start();
    lit("row10", 100, 104, 10, 10, 5, 0);

    repeat (2) begin
      mk_pat(20, 64'h0C63);
      send_line();
      mk_pat(20, 64'h6C6C);
      send_line();
    end
    frame_start();
    lit("runs_of_2", 0, 0, 0, 0, 0, 0);

    mk_pat(20, 64'h6C6C);
    repeat (5) send_line();
    mk_pat(16, 64'h3386);
    send_line();
    frame_start();
    lit("run_of_3", 7, 9, 5, 5, 3, 0);

    empty_lines(200);
    mk_line(320, 300, 319);
    repeat (10) send_line();
    frame_start();
    lit("block", 300, 319, 200, 209, 200, 1);

    mk_line(650, 630, 649);
    send_line();
    frame_start();
    lit("right_edge", 630, 639, 0, 0, 10, 0);

    empty_lines(479);
    mk_line(8, 1, 5);
    send_line();
    mk_line(20, 10, 15);
    send_line();
    frame_start();
    lit("bottom_edge", 1, 5, 479, 479, 5, 0);

    repeat (6) begin
      repeat ($urandom_range(1, 12)) begin
        mk_rand();
        send_line();
      end
      frame_start();
    end

    mk_line(40, 0, 39);
    repeat (2) send_line();
    repeat (10) tick(1, 0, 1, 1);
    rst_n = 1'b0;
    held = '{default: 0};
    exp_q.delete();
    due_q.delete();
    armed = 1'b0;
    #1;
    lit("reset_mid", 0, 0, 0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) tick(0, 0, 0, 0);
    mk_line(40, 0, 39);
    send_line();
    frame_start();
    lit("after_reset_idle", 0, 0, 0, 0, 0, 0);
    empty_lines(1);
    mk_line(30, 20, 29);
    send_line();
    frame_start();
    lit("after_reset", 20, 29, 1, 1, 10, 0);

    repeat (5) tick(0, 0, 0, 0);
    vectors++;
    if (due_q.size() != 0) begin
      miscompares++;
      $display("FAIL report_timeout: %0d pending, want 0",
               due_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eye_bbox_track.md
Name: eye_bbox_track

Overview:
- Downstream consumer of the 1-bit morphology stream (dilated/eroded binary mask) in the eye-tracking pipeline.
- Per frame, finds the bounding box of foreground pixels that belong to horizontal runs of at least MIN_RUN pixels (noise rejection) and counts those pixels.
- At each frame boundary it publishes the box and count, with a one-cycle valid pulse, to the fatigue-decision and overlay logic.

Parameters:
- IMG_W, 640, active pixels per line; columns >= IMG_W are ignored.
- IMG_H, 480, active lines per frame; rows >= IMG_H are ignored.
- COORD_W, 12, width of the row/column counters and coordinate outputs.
- CNT_W, 20, width of the qualifying-pixel counter; saturates at all-ones.
- MIN_RUN, 3, minimum consecutive foreground pixels in a line for the pixels to qualify; range 1..15.
- MIN_PIX, 64, minimum qualifying pixels for bbox_found=1.

Ports:
- module_clk, in, 1, module clock.
- module_rst_n, in, 1, asynchronous active-low reset.
- cam_href, in, 1, line sync; high during a line.
- cam_vsync, in, 1, frame sync; rising edge marks frame start.
- din_val, in, 1, pixel-valid qualifier, sampled on module_clk.
- din, in, 1, binary pixel; 1 = foreground.
- bbox_valid, out, 1, one-cycle pulse when the outputs below update.
- bbox_found, out, 1, 1 if pix_count >= MIN_PIX for the reported frame.
- bbox_x_min, out, COORD_W, leftmost qualifying column.
- bbox_x_max, out, COORD_W, rightmost qualifying column.
- bbox_y_min, out, COORD_W, top qualifying row.
- bbox_y_max, out, COORD_W, bottom qualifying row.
- pix_count, out, CNT_W, qualifying-pixel count of the reported frame.

Behaviour:
- Fixed interface: one clock, module_clk; reset module_rst_n is asynchronous and active-low. All outputs are 0 in reset, and the FSM resets to IDLE.
- Sync handling: cam_href and cam_vsync pass through two flops (r0, r1).
  - vs_rise = r0 & ~r1 on the vsync pair.
  - hs_fall = ~r0 & r1 on the href pair.
- Pixel sampling: din_val and din are sampled directly (no sync) while the FSM is ACTIVE.
- Counters:
  - col counts din_val cycles within a line and holds at IMG_W.
  - row increments on hs_fall and holds at IMG_H.
  - hs_fall clears col and run; vs_rise clears row, col and run.
  - First line = row 0; first pixel = col 0.
- Run filter:
  - run is a 4-bit counter saturating at MIN_RUN.
  - A valid pixel with din=1 increments run; with din=0 it clears run.
  - A pixel qualifies when din=1, run+1 >= MIN_RUN, col < IMG_W and row < IMG_H.
- Qualifying-pixel update:
  - x_lo = col-(MIN_RUN-1) on the cycle run+1 == MIN_RUN (run start, back-filled); otherwise x_lo = col.
  - x_max = max(x_max, col); x_min = min(x_min, x_lo).
  - y_min = min(y_min, row); y_max = max(y_max, row).
  - cnt += MIN_RUN on the first qualifying cycle of a run, += 1 after that; saturating.
- Accumulator init at frame start: x_min/y_min = all-ones, x_max/y_max = 0, cnt = 0, any = 0.
- FSM:
  - IDLE -> ACTIVE on vs_rise.
  - ACTIVE -> REPORT on vs_rise.
  - REPORT -> ACTIVE unconditionally after 1 cycle.
- REPORT cycle:
  - Registers outputs: pix_count=cnt; bbox_found = cnt >= MIN_PIX; bbox_valid=1 for this cycle only.
  - If any=0, all four coordinates output 0; otherwise they output the accumulator values.
  - Clears accumulators; pixels are ignored for this cycle.
- Latency: bbox_valid is asserted 3 cycles after the cam_vsync input rising edge (2 sync flops + REPORT register). Outputs hold until the next REPORT.
- Boundary cases:
  - The first frame after reset is not reported (IDLE discards it).
  - A din_val coinciding with vs_rise or hs_fall is ignored.
  - A pixel arriving in the same cycle as a counter clear is not counted.
  - Reset mid-frame discards all partial state.
  - A frame with no href produces a report with any=0.

Decomposition:
- Shared package (morph_pkg): FSM state encoding {IDLE, ACTIVE, REPORT}, default IMG_W/IMG_H/COORD_W constants.
- One natural sub-module: sync_edge_det (2-flop sync + rise/fall outputs), instantiated for href and vsync.

Test Plan:
- Reset then 2 frames of all-zero din -> first frame not reported; second report: bbox_valid pulse, found=0, coords 0, pix_count 0.
- Frame with row 10 cols 100..104 =1, MIN_RUN=3 -> x_min=100, x_max=104, y_min=y_max=10, pix_count=5, found=0.
- Isolated runs of length 2 scattered (MIN_RUN=3) -> pix_count=0, coords 0; a single run of 3 at row 5 cols 7..9 -> x_min=7, x_max=9, count 3.
- 20x10 block at cols 300..319, rows 200..209 -> box (300,319,200,209), pix_count=200, found=1; bbox_valid exactly 3 cycles after cam_vsync rises, width 1 cycle.
- Foreground at col 639 and beyond IMG_W (extra din_val) -> x_max=639; extra pixels are not counted.
- Assert module_rst_n low mid-frame with active foreground -> all outputs 0 immediately; no report for the next frame (IDLE); the frame after that is reported correctly.
